imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Boot-time sequencer for the instruction memory write port (mem_we/mem_wdata/PC-address).
//  Accepts a little-endian byte stream (e.g. from UART RX) and assembles it into 32-bit words.
//  Writes the words to consecutive word addresses from 0 and holds the CPU in reset meanwhile.
//  Releases the CPU when the image is complete. Sits between the UART RX and the imem/CPU reset mux.
// PARAMETERS
//  MEM_ADDR_WIDTH  10  imem byte-address width; depth = 2**(MEM_ADDR_WIDTH-2) words
//  AUTOBOOT        1   1: start loading after reset; 0: release CPU after reset, load only on load_req
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   synchronous, active-low reset
//  rx_valid     in   1   byte available on rx_data
//  rx_data      in   8   stream byte
//  rx_ready     out  1   loader accepts byte this cycle (transfer = rx_valid & rx_ready)
//  load_req     in   1   restart load; sampled only in DONE/ERR
//  mem_we       out  1   imem write strobe, 1-cycle pulse
//  mem_wdata    out  32  imem write data
//  mem_addr     out  MEM_ADDR_WIDTH  imem byte address, bits[1:0] always 0
//  cpu_rst_n    out  1   CPU reset, active-low; 0 while loading
//  busy         out  1   1 in HDR/DATA/WRITE/CSUM
//  done         out  1   1 in DONE
//  err          out  1   1 in ERR
// BEHAVIOUR
//  Reset: state IDLE; rx_ready=0, mem_we=0, mem_wdata=0, mem_addr=0, cpu_rst_n=0, busy=0, done=0, err=0.
//  Protocol: 4-byte LE word count N, then N words of 4 bytes each, LE (first byte -> [7:0]).
//  IDLE: 1 cycle; AUTOBOOT=1 -> HDR; AUTOBOOT=0 -> DONE.
//  HDR: rx_ready=1; shift in 4 bytes to 32-bit count register.
//   After 4th byte: N=0 -> DONE (or CSUM if enabled); N>depth -> ERR; else DATA.
//  DATA: rx_ready=1; collect 4 bytes into mem_wdata; the 4th accepted byte -> WRITE.
//  WRITE: rx_ready=0; mem_we=1 for exactly 1 cycle with the current mem_addr/mem_wdata.
//   Next cycle: mem_addr += 4 and remaining count -= 1. Remaining=0 -> DONE (or CSUM); else DATA.
//   Latency from the 4th byte handshake to the mem_we high cycle: 1 clk.
//  DONE: cpu_rst_n=1, done=1, rx_ready=0; rx bytes are not consumed.
//   load_req=1 -> HDR; on that edge cpu_rst_n=0, mem_addr=0, byte counter=0.
//  ERR: cpu_rst_n=0, err=1, rx_ready=0; load_req=1 -> HDR (same clears as DONE).
//  load_req in IDLE/HDR/DATA/WRITE/CSUM: ignored.
//  Byte position counter 2 bits, wraps 3->0 per word. mem_addr must not wrap: N<=depth guaranteed by HDR check.
//  N==depth is legal: the last write goes to the top word, then mem_addr holds depth*4 truncated (0). It is unused.
//  rx_valid low mid-word: hold state and partial word indefinitely; no timeout.
//  rst_n low in any state: immediate return to reset values on that edge.
//   Partially written imem contents are not cleared.
//  mem_wdata holds the last written word after the write; it is only meaningful while mem_we=1.
// CONFIGURATION
//  Macro IMEM_LOADER_CHECKSUM_EN:
//   Defined: running XOR of all payload bytes (count bytes excluded), init 8'h00 on entering HDR.
//    After the last word (or N=0) -> CSUM: accept 1 byte; equal to XOR -> DONE, else -> ERR.
//    A failed image leaves the CPU held in reset.
//   Undefined: no CSUM state; last write (or N=0) -> DONE directly; no trailing byte is consumed.
// TESTING
//  1 AUTOBOOT=1, stream 02 00 00 00 | 13 00 00 00 | 6F 00 00 00 -> mem_we pulses at addr 0x000 data 0x00000013
//    and addr 0x004 data 0x0000006F; done=1, cpu_rst_n=1 (with CSUM_EN append 7C -> same result).
//  2 Count 00 00 00 00 -> no mem_we; DONE after header (CSUM_EN: byte 00 -> DONE).
//  3 Count 01 01 00 00 (257 > 256 words) -> ERR, err=1, cpu_rst_n=0, rx_ready=0.
//    Then load_req + valid 1-word image -> DONE.
//  4 rx_valid toggled 1/0 every cycle for a 1-word image EF BE AD DE -> single write data 0xDEADBEEF at 0x000.
//    rx_ready=0 in the WRITE cycle only.
//  5 rst_n asserted after 2 of 4 data bytes -> all outputs at reset values next cycle; reload from HDR succeeds.
//  6 CSUM_EN: 1-word image 01 02 03 04, checksum 05 -> ERR (expected 04); load_req ignored while busy.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream (count N, then N words) into imem writes
// while holding the CPU in reset. Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned AUTOBOOT       = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_data,
  output logic                      rx_ready,
  input  logic                      load_req,
  output logic                      mem_we,
  output logic [31:0]               mem_wdata,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic                      cpu_rst_n,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned DEPTH = 2 ** (MEM_ADDR_WIDTH - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DATA, S_WRITE, S_DONE, S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = S_CSUM;
`else
  localparam state_t END_ST = S_DONE;
`endif

  state_t                      state_q, state_d;
  logic [31:0]                 cnt_q, cnt_d;
  logic [1:0]                  pos_q, pos_d;
  logic [31:0]                 wdata_q, wdata_d;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                        xfer;
  logic [31:0]                 hdr_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]                  csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pos_q   <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    rx_ready  = (state_q == S_HDR) || (state_q == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
    rx_ready  = rx_ready || (state_q == S_CSUM);
`endif
    mem_we    = (state_q == S_WRITE);
    busy      = rx_ready || mem_we;
    done      = (state_q == S_DONE);
    err       = (state_q == S_ERR);
    cpu_rst_n = done;
    mem_wdata = wdata_q;
    mem_addr  = addr_q;
  end

  // Count and data bytes shift in from the top so the first byte lands in [7:0].
  assign xfer     = rx_valid && rx_ready;
  assign hdr_word = {rx_data, cnt_q[31:8]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: state_d = (AUTOBOOT != 0) ? S_HDR : S_DONE;
      S_HDR: begin
        if (xfer) begin
          cnt_d = hdr_word;
          pos_d = pos_q + 2'd1;
          if (pos_q == 2'd3) begin
            if (hdr_word == '0)               state_d = END_ST;
            else if (hdr_word > 32'(DEPTH))   state_d = S_ERR;
            else                              state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          wdata_d = {rx_data, wdata_q[31:8]};
          pos_d   = pos_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
          if (pos_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + MEM_ADDR_WIDTH'(4);
        cnt_d   = cnt_q - 32'd1;
        state_d = (cnt_q == 32'd1) ? END_ST : S_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (load_req) begin
          state_d = S_HDR;
          addr_d  = '0;
          pos_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: expected writes are queued as bytes are sent and
// popped by a monitor whenever mem_we is seen.
module tb_imem_boot_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        load_req;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [9:0]  mem_addr;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [9:0] exp_addr;
  logic [7:0] csum;

  imem_boot_loader #(.MEM_ADDR_WIDTH(10), .AUTOBOOT(1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .load_req(load_req), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'(exp_q.size()), 32'd1);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", mem_wdata, e.data);
        chk("wr_rx_ready", 32'(rx_ready), 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send_byte(input logic [7:0] b);
    int unsigned n;
    logic acc;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    do begin
      acc = rx_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 64);
    rx_valid = 1'b0;
    if (!acc) chk("rx_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_hdr(input logic [31:0] n);
    csum     = 8'h00;
    exp_addr = '0;
    for (int unsigned i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    wr_t e;
    e.addr = exp_addr;
    e.data = w;
    exp_q.push_back(e);
    exp_addr = exp_addr + 10'd4;
    for (int unsigned i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      csum = csum ^ w[8*i +: 8];
      if (i == 3) chk("we_latency", 32'(mem_we), 32'd1);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic finish_image(input logic [7:0] delta);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(csum ^ delta);
`else
    if (delta != 8'h00) @(negedge clk);
`endif
  endtask

  task automatic wait_idle_out();
    int unsigned n;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("end_busy", 32'(busy), 32'd0);
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    chk("req_busy", 32'(busy), 32'd1);
    chk("req_cpu_rst", 32'(cpu_rst_n), 32'd0);
    chk("req_addr", 32'(mem_addr), 32'd0);
  endtask

  task automatic chk_done();
    chk("done", 32'(done), 32'd1);
    chk("done_cpu_rst", 32'(cpu_rst_n), 32'd1);
    chk("done_err", 32'(err), 32'd0);
    chk("done_rx_ready", 32'(rx_ready), 32'd0);
  endtask

  task automatic chk_reset();
    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; load_req = 1'b0;
    csum = 8'h00; exp_addr = '0;
    repeat (3) @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    @(negedge clk);
    chk("hdr_busy", 32'(busy), 32'd1);
    chk("hdr_rx_ready", 32'(rx_ready), 32'd1);

    // Two-word image.
    send_hdr(32'd2);
    send_word(32'h0000_0013, 1'b0);
    send_word(32'h0000_006F, 1'b0);
    finish_image(8'h00);
    wait_idle_out();
    chk_done();
    rx_valid = 1'b1; rx_data = 8'hAA;
    repeat (2) begin
      @(negedge clk);
      chk("done_hold_rx", 32'(rx_ready), 32'd0);
    end
    rx_valid = 1'b0;

    // Empty image.
    pulse_req();
    send_hdr(32'd0);
    finish_image(8'h00);
    wait_idle_out();
    chk_done();

    // Oversized count, then recovery.
    pulse_req();
    send_hdr(32'd257);
    @(negedge clk);
    chk("err", 32'(err), 32'd1);
    chk("err_cpu_rst", 32'(cpu_rst_n), 32'd0);
    chk("err_rx_ready", 32'(rx_ready), 32'd0);
    pulse_req();
    send_hdr(32'd1);
    send_word(32'h1234_5678, 1'b0);
    finish_image(8'h00);
    wait_idle_out();
    chk_done();

    // Full-depth image; address wraps to 0 after the top word.
    pulse_req();
    send_hdr(32'd256);
    for (int unsigned i = 0; i < 256; i++) send_word(32'h1000_0000 + i * 32'h0001_0203, 1'b0);
    finish_image(8'h00);
    wait_idle_out();
    chk_done();
    chk("depth_addr_wrap", 32'(mem_addr), 32'd0);

    // Valid toggling every cycle.
    pulse_req();
    send_hdr(32'd1);
    send_word(32'hDEAD_BEEF, 1'b1);
    finish_image(8'h00);
    wait_idle_out();
    chk_done();

    // Reset mid-word, then reload.
    pulse_req();
    send_hdr(32'd1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset();
    rst_n = 1'b1;
    send_hdr(32'd1);
    send_word(32'h4433_2211, 1'b0);
    finish_image(8'h00);
    wait_idle_out();
    chk_done();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Bad checksum with load_req asserted while busy.
    pulse_req();
    load_req = 1'b1;
    send_hdr(32'd1);
    send_word(32'h0403_0201, 1'b0);
    load_req = 1'b0;
    send_byte(8'h05);
    chk("csum_err", 32'(err), 32'd1);
    chk("csum_cpu_rst", 32'(cpu_rst_n), 32'd0);
`endif

    repeat (2) @(negedge clk);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
